operand_select_stage: RTL and testbench

- Parametrised, registered successor to the ALU operand-select mux in the EX stage.
- Selects one of NUM_SRC forwarded operand sources, or the immediate, and registers the result into a 1-deep output stage backed by a skid entry.
- Uses a valid/ready handshake, so the hazard unit stalls it with backpressure instead of re-muxing.
- Sits between the forwarding unit / ID-EX register and the ALU operand input.

---
 rtl/operand_select_stage.sv | 108 ++++++++++
 tb/tb_operand_select_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/operand_select_stage.sv
// Registered ALU operand-select stage: picks a forwarded source or the immediate
// into a main/skid pair with valid/ready flow. Optional sticky select-error flag: OPERAND_SEL_ERR_EN.
module operand_select_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEL_W   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [SEL_W-1:0]         sel_i,
    input  logic                     imm_sel_i,
    input  logic [WIDTH-1:0]         imm_i,
    input  logic [NUM_SRC*WIDTH-1:0] data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WIDTH-1:0]         data_o
`ifdef OPERAND_SEL_ERR_EN
    ,
    output logic                     sel_err_o
`endif
);

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    logic [WIDTH-1:0] sel_result;
    logic             sel_oob;
    int unsigned      sel_idx;

    logic in_xfer;
    logic out_xfer;
    logic main_free;

    // Out-of-range selects fall back to source 0.
    always_comb begin
        sel_idx    = 32'(sel_i);
        sel_oob    = !imm_sel_i && (sel_idx >= NUM_SRC);
        sel_result = data_i[0 +: WIDTH];
        if (imm_sel_i) begin
            sel_result = imm_i;
        end else begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                if (sel_idx == k) begin
                    sel_result = data_i[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign in_ready_o  = !skid_valid;
    assign out_valid_o = main_valid;
    assign data_o      = main_data;

    assign in_xfer   = in_valid_i && in_ready_o;
    assign out_xfer  = main_valid && out_ready_i;
    assign main_free = !main_valid || out_xfer;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (main_free) begin
                if (skid_valid) begin
                    main_valid <= 1'b1;
                    main_data  <= skid_data;
                end else if (in_xfer) begin
                    main_valid <= 1'b1;
                    main_data  <= sel_result;
                end else begin
                    main_valid <= 1'b0;
                end
            end
            // in_xfer implies skid is empty, so the skid only ever fills behind a stalled main.
            if (in_xfer && !main_free) begin
                skid_valid <= 1'b1;
                skid_data  <= sel_result;
            end else if (main_free && skid_valid) begin
                skid_valid <= 1'b0;
            end
        end
    end

`ifdef OPERAND_SEL_ERR_EN
    logic sel_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_err_q <= 1'b0;
        end else if (in_xfer && sel_oob) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err_o = sel_err_q;
`endif

endmodule

// File: tb/tb_operand_select_stage.sv
// Directed plus randomized bench for operand_select_stage (NUM_SRC=3) against a
// queue-based reference model; checks sel_err_o when OPERAND_SEL_ERR_EN is defined.
module tb_operand_select_stage;

    localparam int unsigned W   = 32;
    localparam int unsigned NS  = 3;
    localparam int unsigned SW  = 2;

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [SW-1:0]     sel_i = '0;
    logic              imm_sel_i = 1'b0;
    logic [W-1:0]      imm_i = '0;
    logic [NS*W-1:0]   data_i;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [W-1:0]      data_o;
`ifdef OPERAND_SEL_ERR_EN
    logic              sel_err_o;
`endif

    logic [W-1:0] src [NS];

    always #5 clk = ~clk;

    always_comb begin
        data_i = '0;
        for (int k = 0; k < int'(NS); k++) data_i[k*W +: W] = src[k];
    end

    operand_select_stage #(.WIDTH(W), .NUM_SRC(NS), .SEL_W(SW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .sel_i       (sel_i),
        .imm_sel_i   (imm_sel_i),
        .imm_i       (imm_i),
        .data_i      (data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .data_o      (data_o)
`ifdef OPERAND_SEL_ERR_EN
        ,
        .sel_err_o   (sel_err_o)
`endif
    );

    // Reference: ordered list of held operands (at most two), plus the last shown value.
    logic [W-1:0] mq [$];
    logic [W-1:0] m_data = '0;
    logic         m_err  = 1'b0;
    int checks = 0;
    int errors = 0;

    function automatic logic [W-1:0] ref_select();
        if (imm_sel_i) return imm_i;
        if (int'(sel_i) < int'(NS)) return src[sel_i];
        return src[0];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, updating the model from pre-edge inputs, then check outputs.
    task automatic step(input string tag);
        logic         acc, pop;
        logic [W-1:0] val;
        acc = in_valid_i && (mq.size() < 2);
        pop = (mq.size() > 0) && out_ready_i;
        val = ref_select();
        @(posedge clk);
        #1;
        if (rst_i) begin
            mq.delete();
            m_data = '0;
            m_err  = 1'b0;
        end else begin
            if (acc && !imm_sel_i && int'(sel_i) >= int'(NS)) m_err = 1'b1;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (acc) mq.push_back(val);
                if (mq.size() > 0) m_data = mq[0];
            end
        end
        chk({tag, ".in_ready"}, W'(in_ready_o), W'(mq.size() < 2));
        chk({tag, ".out_valid"}, W'(out_valid_o), W'(mq.size() > 0));
        if (mq.size() > 0) chk({tag, ".data"}, data_o, m_data);
`ifdef OPERAND_SEL_ERR_EN
        chk({tag, ".sel_err"}, W'(sel_err_o), W'(m_err));
`endif
    endtask

    task automatic fill_both();
        out_ready_i = 1'b0; in_valid_i = 1'b1; imm_sel_i = 1'b1;
        imm_i = 32'hAAAA_0001; step("fill1");
        imm_i = 32'hAAAA_0002; step("fill2");
        chk("fill.stalled_ready", W'(in_ready_o), W'(0));
    endtask

    initial begin
        for (int k = 0; k < int'(NS); k++) src[k] = 32'h1000 + W'(k);

        rst_i = 1'b1; step("reset");
        chk("reset.data_zero", data_o, '0);
        rst_i = 1'b0;

        src[2] = 32'hDEAD_BEEF; sel_i = 2'd2; in_valid_i = 1'b1; out_ready_i = 1'b1;
        step("src2");
        chk("src2.value", data_o, 32'hDEAD_BEEF);
        in_valid_i = 1'b0; step("src2.drain");

        imm_sel_i = 1'b1; imm_i = 32'hFFFF_FFF0; sel_i = 2'd1; in_valid_i = 1'b1;
        step("imm");
        chk("imm.value", data_o, 32'hFFFF_FFF0);
        in_valid_i = 1'b0; step("imm.drain");

        out_ready_i = 1'b0; in_valid_i = 1'b1;
        imm_i = 32'd1; step("stall.A");
        imm_i = 32'd2; step("stall.B");
        chk("stall.ready_low", W'(in_ready_o), W'(0));
        imm_i = 32'd3; step("stall.C_blocked");
        chk("stall.head_A", data_o, 32'd1);
        out_ready_i = 1'b1;
        step("release.B");
        chk("release.order_B", data_o, 32'd2);
        step("release.C");
        chk("release.order_C", data_o, 32'd3);
        in_valid_i = 1'b0; step("release.drain");

        imm_sel_i = 1'b0; sel_i = 2'd3; src[0] = 32'h11; in_valid_i = 1'b1;
        step("oob");
        chk("oob.value", data_o, 32'h11);
        in_valid_i = 1'b0; flush_i = 1'b1; step("oob.flush");
        flush_i = 1'b0;

        fill_both();
        flush_i = 1'b1; in_valid_i = 1'b1; imm_i = 32'hBAD0_BAD0; step("flush");
        chk("flush.data_kept", data_o, 32'hAAAA_0001);
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        step("flush.no_ghost");

        fill_both();
        rst_i = 1'b1; step("mid_reset");
        chk("mid_reset.data_zero", data_o, '0);
        rst_i = 1'b0;

        for (int n = 0; n < 400; n++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            imm_sel_i   = ($urandom_range(0, 3) == 0);
            sel_i       = SW'($urandom_range(0, 3));
            imm_i       = $urandom;
            for (int k = 0; k < int'(NS); k++) src[k] = $urandom;
            flush_i     = ($urandom_range(0, 19) == 0);
            rst_i       = ($urandom_range(0, 99) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
